// File: rtl/mxv_ctrl_seq.sv
// Frame sequencer for the matrix-vector engine: FIFO load, staggered pop ramp, UART result frame.
// Optional synchronous abort input is compiled in when MXV_CTRL_ABORT_EN is defined.
module mxv_ctrl_seq #(
  parameter int                NUM_CH     = 4,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] START_BYTE = 8'hFE,
  parameter logic [DATA_W-1:0] CMD_BYTE   = 8'h04,
  parameter logic [DATA_W-1:0] TRAIL_BYTE = 8'hEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic              end_load,
  input  logic              op_step,
  input  logic              end_op,
  input  logic              end_tx_results,
  input  logic [DATA_W-1:0] matrix_length,
  input  logic              tx_ready,
  input  logic              tx_done,
`ifdef MXV_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              enable_counter,
  output logic              op_in_process,
  output logic [NUM_CH-1:0] pop,
  output logic              transmit,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              last_cmd,
  output logic              frame_done
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WAIT_REL = 4'd1;
  localparam logic [3:0] ST_LOAD     = 4'd2;
  localparam logic [3:0] ST_RAMP     = 4'd3;
  localparam logic [3:0] ST_FULL     = 4'd4;
  localparam logic [3:0] ST_START    = 4'd5;
  localparam logic [3:0] ST_LEN      = 4'd6;
  localparam logic [3:0] ST_CMD      = 4'd7;
  localparam logic [3:0] ST_TX_RES   = 4'd8;
  localparam logic [3:0] ST_TRAIL    = 4'd9;

  localparam logic [NUM_CH-1:0] POP_ONE = NUM_CH'(1'b1);

  logic [3:0]        state_q, state_d;
  logic              sent_q, sent_d;
  logic [NUM_CH-1:0] pop_q, pop_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic              tx_en_q, tx_en_d;
  logic              frame_done_q, frame_done_d;
  logic              enable_counter_q, enable_counter_d;
  logic              op_in_process_q, op_in_process_d;
  logic              transmit_q, transmit_d;
  logic              last_cmd_q, last_cmd_d;
  logic              pop_step_s;
  logic              entry_s;
  logic              abort_s;

`ifdef MXV_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  function automatic logic is_send(input logic [3:0] st);
    case (st)
      ST_START, ST_LEN, ST_CMD, ST_TRAIL: is_send = 1'b1;
      default:                            is_send = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] send_next(input logic [3:0] st);
    case (st)
      ST_START: send_next = ST_LEN;
      ST_LEN:   send_next = ST_CMD;
      ST_CMD:   send_next = ST_TX_RES;
      default:  send_next = ST_IDLE;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] send_byte(input logic [3:0] st, input logic [DATA_W-1:0] len);
    case (st)
      ST_START: send_byte = START_BYTE;
      ST_LEN:   send_byte = len;
      ST_CMD:   send_byte = CMD_BYTE;
      ST_TRAIL: send_byte = TRAIL_BYTE;
      default:  send_byte = {DATA_W{1'b0}};
    endcase
  endfunction

  // Next-state decision plus the one-cycle byte strobe and frame-complete pulse.
  always_comb begin
    state_d      = state_q;
    tx_en_d      = 1'b0;
    frame_done_d = 1'b0;
    pop_step_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_load) state_d = ST_WAIT_REL;
        else            state_d = ST_IDLE;
      end
      ST_WAIT_REL: begin
        if (!start_load) state_d = ST_LOAD;
        else             state_d = ST_WAIT_REL;
      end
      ST_LOAD: begin
        if (end_load) state_d = ST_RAMP;
        else          state_d = ST_LOAD;
      end
      ST_RAMP: begin
        // end_op wins over op_step so short matrices can skip the rest of the ramp
        if (end_op)       state_d = ST_START;
        else if (&pop_q)  state_d = ST_FULL;
        else begin
          state_d    = ST_RAMP;
          pop_step_s = op_step;
        end
      end
      ST_FULL: begin
        if (end_op) state_d = ST_START;
        else        state_d = ST_FULL;
      end
      ST_START, ST_LEN, ST_CMD, ST_TRAIL: begin
        // phase A (sent_q=0) waits for tx_ready; phase B waits for tx_done
        if (!sent_q) begin
          tx_en_d = tx_ready;
          state_d = state_q;
        end else if (tx_done) begin
          state_d      = send_next(state_q);
          frame_done_d = (state_q == ST_TRAIL);
        end else begin
          state_d = state_q;
        end
      end
      ST_TX_RES: begin
        if (end_tx_results) state_d = ST_TRAIL;
        else                state_d = ST_TX_RES;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_s && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      tx_en_d      = 1'b0;
      frame_done_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Datapath registers: send phase, byte latch, length capture, pop ramp and state decodes.
  always_comb begin
    entry_s   = (state_d != state_q);
    sent_d    = entry_s ? 1'b0 : (sent_q | tx_en_d);
    tx_data_d = (entry_s && is_send(state_d)) ? send_byte(state_d, len_q) : tx_data_q;
    len_d     = ((state_q == ST_IDLE) && (state_d == ST_WAIT_REL)) ? matrix_length : len_q;
    if ((state_d != ST_RAMP) && (state_d != ST_FULL)) begin
      pop_d = {NUM_CH{1'b0}};
    end else if ((state_q != ST_RAMP) && (state_q != ST_FULL)) begin
      pop_d = POP_ONE;
    end else if (pop_step_s) begin
      pop_d = (pop_q << 1'b1) | POP_ONE;
    end else begin
      pop_d = pop_q;
    end
    enable_counter_d = (state_d == ST_LOAD);
    op_in_process_d  = (state_d == ST_RAMP) || (state_d == ST_FULL);
    transmit_d       = (state_d == ST_TX_RES);
    last_cmd_d       = (state_d == ST_TRAIL);
  end

  // State and output flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      sent_q           <= 1'b0;
      pop_q            <= {NUM_CH{1'b0}};
      tx_data_q        <= {DATA_W{1'b0}};
      len_q            <= {DATA_W{1'b0}};
      tx_en_q          <= 1'b0;
      frame_done_q     <= 1'b0;
      enable_counter_q <= 1'b0;
      op_in_process_q  <= 1'b0;
      transmit_q       <= 1'b0;
      last_cmd_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      sent_q           <= sent_d;
      pop_q            <= pop_d;
      tx_data_q        <= tx_data_d;
      len_q            <= len_d;
      tx_en_q          <= tx_en_d;
      frame_done_q     <= frame_done_d;
      enable_counter_q <= enable_counter_d;
      op_in_process_q  <= op_in_process_d;
      transmit_q       <= transmit_d;
      last_cmd_q       <= last_cmd_d;
    end
  end

  assign enable_counter = enable_counter_q;
  assign op_in_process  = op_in_process_q;
  assign pop            = pop_q;
  assign transmit       = transmit_q;
  assign tx_en          = tx_en_q;
  assign tx_data        = tx_data_q;
  assign last_cmd       = last_cmd_q;
  assign frame_done     = frame_done_q;

endmodule
